mem_issue_ctrl: RTL and testbench
=================================

// Module: mem_issue_ctrl
// PURPOSE
// - Sequences one load/store at a time from the load/store queue head onto the single-port data cache.
// - Address gen, byte-lane alignment, request hold until cache resp, load extract/extend, ROB writeback.
// - Drives in_flight_mem back to the queue so it pops only when this block is idle.
// PARAMETERS
// ROB_ID_W   5   width of ROB tag carried with each access
// PORTS
// clk           in   1         clock, all state on rising edge
// rst           in   1         asynchronous, active-low reset (low = reset)
// issue_valid   in   1         head entry presented this cycle (both operands ready)
// issue_store   in   1         1 = store, 0 = load
// issue_funct3  in   3         RV32I load/store funct3
// issue_rs1_v   in   32        base register value
// issue_rs2_v   in   32        store data
// issue_imm     in   32        sign-extended offset
// issue_rob_id  in   ROB_ID_W  destination ROB tag
// flush         in   1         squash in-flight access result (mispredict)
// in_flight_mem out  1         high whenever state != IDLE
// dmem_addr     out  32        word-aligned address {ea[31:2],2'b00}
// dmem_rmask    out  4         load byte enables
// dmem_wmask    out  4         store byte enables
// dmem_wdata    out  32        store data, lane-shifted
// dmem_rdata    in   32        cache read data, valid with dmem_resp
// dmem_resp     in   1         one-cycle completion pulse
// cdb_valid     out  1         one-cycle writeback pulse to ROB
// cdb_rob_id    out  ROB_ID_W  tag of completed access
// cdb_data      out  32        load result (0 for store; faulting ea on exception)
// cdb_exc       out  1         misaligned-access exception flag
// BEHAVIOUR
// - Reset: state=IDLE; in_flight_mem, masks, cdb_valid, cdb_exc =0; addr, wdata, cdb_data, cdb_rob_id =0.
// - FSM IDLE -> REQ -> WB -> IDLE. Only IDLE samples issue; issue_valid while busy is ignored (bench asserts never).
// - IDLE: issue_valid=1 registers ea=rs1_v+imm (mod 2^32), funct3, rob_id, store, off=ea[1:0]; next REQ.
// - REQ: masks/addr/wdata registered, stable every cycle until dmem_resp. exactly one of rmask/wmask nonzero.
//   Byte mask base: funct3[1:0]=00 ->0001, 01 ->0011, 10 ->1111; shifted left by off, truncated to 4 bits.
//   wdata = rs2_v << (8*off). dmem_resp -> masks drop to 0 the next cycle; capture rdata; next WB.
// - WB: cdb_valid=1 for exactly one cycle; load data = rdata >> (8*off), then LB/LH sign-extend,
//   LBU/LHU (funct3 100/101) zero-extend, LW pass. Store: cdb_data=0. Next IDLE.
// - Latency: issue at cycle N, request visible N+1; resp at M -> cdb_valid at M+1; new issue accepted M+2.
// - Back-to-back: next issue accepted the cycle after WB (in_flight_mem low in IDLE).
// - flush in IDLE: no effect. flush in REQ: request stays held until dmem_resp (cache cannot cancel),
//   then IDLE with no cdb_valid. flush in WB: cdb_valid suppressed. Flush is sticky until leaving REQ.
// - flush and issue_valid same cycle in IDLE: issue dropped.
// - Reset asserted mid-REQ: immediate return to IDLE, masks 0; late dmem_resp in IDLE is ignored.
// - Illegal funct3 (011, 11x; load 11x / store 1xx): treated as word access, no error.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: in IDLE, halfword with ea[0]=1 or word with ea[1:0]!=0 skips REQ,
//   goes directly to WB with cdb_exc=1, cdb_data=ea; no dmem masks ever asserted for it.
// - Not defined: misaligned accesses issue normally with truncated mask (bytes past word dropped);
//   cdb_exc tied 0.
// TESTING
// - LW rs1=0x1000 imm=4, resp after 3 cycles, rdata=0xDEADBEEF -> addr 0x1004 rmask 1111, cdb_data 0xDEADBEEF.
// - LB ea=0x2003, rdata=0x80FF_FF00 -> rmask 1000, cdb_data 0xFFFFFF80; LBU same -> 0x00000080.
// - SH ea=0x3002 rs2=0x1234ABCD -> wmask 1100, wdata 0xABCD0000, cdb_valid store cdb_data 0.
// - flush one cycle into REQ, resp 2 cycles later -> masks held until resp, no cdb_valid, IDLE next.
// - LW ea=0x4001 -> with MISALIGN_TRAP_EN: no mask, cdb_exc=1 cdb_data=0x4001; without: rmask 1110.
// - rst low during REQ then resp pulse -> outputs at reset values, no cdb_valid; next issue works.

Source files
------------

// File: rtl/mem_issue_ctrl.sv
// mem_issue_ctrl: single-outstanding load/store sequencer onto the data cache; optional MISALIGN_TRAP_EN traps misaligned accesses
module mem_issue_ctrl #(
  parameter int ROB_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_store,
  input  logic [2:0]          issue_funct3,
  input  logic [31:0]         issue_rs1_v,
  input  logic [31:0]         issue_rs2_v,
  input  logic [31:0]         issue_imm,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic                flush,
  output logic                in_flight_mem,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_rmask,
  output logic [3:0]          dmem_wmask,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_resp,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [31:0]         cdb_data,
  output logic                cdb_exc
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  state_t      state;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic        st, fl, wb_valid;
  logic [31:0] ea, sh, ld;
  logic [1:0]  size;
  logic [3:0]  mask;
  logic        misal;
  assign in_flight_mem = state != IDLE;
  // A flush landing in the writeback cycle still kills the result.
  assign cdb_valid = wb_valid & ~flush;
  // Address generation, access size (illegal encodings fall back to word) and lane mask.
  always_comb begin
    ea   = issue_rs1_v + issue_imm;
    size = (issue_funct3[1] | (issue_store & issue_funct3[2])) ? 2'd2 : {1'b0, issue_funct3[0]};
    mask = (size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111) << ea[1:0];
`ifdef MISALIGN_TRAP_EN
    misal = (size == 2'd1 && ea[0]) || (size == 2'd2 && ea[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
  end
  // Load result: shift selected lanes down, then sign/zero extend by funct3.
  always_comb begin
    sh = dmem_rdata >> {off, 3'b000};
    ld = f3[1] ? sh
       : f3[0] ? {{16{sh[15] & ~f3[2]}}, sh[15:0]}
       : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
  end
  // IDLE -> REQ -> WB -> IDLE sequencer with registered cache and writeback outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      off        <= '0;
      f3         <= '0;
      st         <= 1'b0;
      fl         <= 1'b0;
      wb_valid   <= 1'b0;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      cdb_rob_id <= '0;
      cdb_data   <= '0;
      cdb_exc    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue_valid && !flush) begin
          off        <= ea[1:0];
          f3         <= issue_funct3;
          st         <= issue_store;
          fl         <= 1'b0;
          cdb_rob_id <= issue_rob_id;
          cdb_exc    <= misal;
          if (misal) begin
            state    <= WB;
            wb_valid <= 1'b1;
            cdb_data <= ea;
          end else begin
            state      <= REQ;
            dmem_addr  <= {ea[31:2], 2'b00};
            dmem_rmask <= issue_store ? 4'b0000 : mask;
            dmem_wmask <= issue_store ? mask : 4'b0000;
            dmem_wdata <= issue_rs2_v << {ea[1:0], 3'b000};
          end
        end
        REQ: if (dmem_resp) begin
          dmem_rmask <= '0;
          dmem_wmask <= '0;
          if (fl || flush) state <= IDLE;
          else begin
            state    <= WB;
            wb_valid <= 1'b1;
            cdb_data <= st ? 32'h0 : ld;
          end
        end else if (flush) fl <= 1'b1;
        default: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          cdb_exc  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_issue_ctrl.sv
// tb_mem_issue_ctrl: directed checks of mem_issue_ctrl sequencing, lane handling, flush and reset
module tb_mem_issue_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        issue_valid = 1'b0, issue_store = 1'b0, flush = 1'b0, dmem_resp = 1'b0;
  logic [2:0]  issue_funct3 = '0;
  logic [31:0] issue_rs1_v = '0, issue_rs2_v = '0, issue_imm = '0, dmem_rdata = '0;
  logic [4:0]  issue_rob_id = '0, cdb_rob_id;
  logic        in_flight_mem, cdb_valid, cdb_exc;
  logic [31:0] dmem_addr, dmem_wdata, cdb_data;
  logic [3:0]  dmem_rmask, dmem_wmask;
  int checks = 0, failures = 0;

  mem_issue_ctrl #(.ROB_ID_W(5)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_store(issue_store),
    .issue_funct3(issue_funct3), .issue_rs1_v(issue_rs1_v), .issue_rs2_v(issue_rs2_v),
    .issue_imm(issue_imm), .issue_rob_id(issue_rob_id), .flush(flush),
    .in_flight_mem(in_flight_mem), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_data(cdb_data), .cdb_exc(cdb_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic do_issue(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [4:0] r);
    @(negedge clk);
    issue_valid = 1'b1; issue_store = s; issue_funct3 = f;
    issue_rs1_v = a; issue_rs2_v = b; issue_imm = i; issue_rob_id = r;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic do_resp(input logic [31:0] d);
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = d;
    @(negedge clk);
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    #1;
    chk("rst_inflight", {31'b0, in_flight_mem}, 0);
    chk("rst_rmask", {28'b0, dmem_rmask}, 0);
    chk("rst_wmask", {28'b0, dmem_wmask}, 0);
    chk("rst_cdb_valid", {31'b0, cdb_valid}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_cdb_data", cdb_data, 0);
    @(negedge clk); rst = 1'b1;
    // LW 0x1000+4, response three cycles after issue
    do_issue(1'b0, 3'b010, 32'h1000, 32'h0, 32'h4, 5'd3);
    chk("lw_inflight", {31'b0, in_flight_mem}, 1);
    chk("lw_addr", dmem_addr, 32'h1004);
    chk("lw_rmask", {28'b0, dmem_rmask}, 4'b1111);
    chk("lw_wmask", {28'b0, dmem_wmask}, 0);
    repeat (2) @(negedge clk);
    chk("lw_rmask_held", {28'b0, dmem_rmask}, 4'b1111);
    do_resp(32'hDEADBEEF);
    chk("lw_cdb_valid", {31'b0, cdb_valid}, 1);
    chk("lw_cdb_data", cdb_data, 32'hDEADBEEF);
    chk("lw_cdb_rob", {27'b0, cdb_rob_id}, 3);
    chk("lw_rmask_drop", {28'b0, dmem_rmask}, 0);
    chk("lw_exc", {31'b0, cdb_exc}, 0);
    @(negedge clk);
    chk("lw_cdb_pulse", {31'b0, cdb_valid}, 0);
    chk("lw_idle", {31'b0, in_flight_mem}, 0);
    // LB 0x2003: top byte 0x80 sign-extends
    do_issue(1'b0, 3'b000, 32'h2000, 32'h0, 32'h3, 5'd4);
    chk("lb_rmask", {28'b0, dmem_rmask}, 4'b1000);
    chk("lb_addr", dmem_addr, 32'h2000);
    do_resp(32'h80FFFF00);
    chk("lb_cdb_data", cdb_data, 32'hFFFFFF80);
    @(negedge clk);
    // LBU same address zero-extends
    do_issue(1'b0, 3'b100, 32'h2000, 32'h0, 32'h3, 5'd5);
    do_resp(32'h80FFFF00);
    chk("lbu_cdb_data", cdb_data, 32'h00000080);
    chk("lbu_cdb_rob", {27'b0, cdb_rob_id}, 5);
    @(negedge clk);
    // SH 0x3002 shifts store data into upper half
    do_issue(1'b1, 3'b001, 32'h3000, 32'h1234ABCD, 32'h2, 5'd6);
    chk("sh_wmask", {28'b0, dmem_wmask}, 4'b1100);
    chk("sh_rmask", {28'b0, dmem_rmask}, 0);
    chk("sh_wdata", dmem_wdata, 32'hABCD0000);
    do_resp(32'h55555555);
    chk("sh_cdb_valid", {31'b0, cdb_valid}, 1);
    chk("sh_cdb_data", cdb_data, 0);
    chk("sh_wmask_drop", {28'b0, dmem_wmask}, 0);
    @(negedge clk);
    // flush one cycle into REQ: request held, result squashed
    do_issue(1'b0, 3'b010, 32'h5000, 32'h0, 32'hFFFFFFFC, 5'd7);
    chk("fl_addr", dmem_addr, 32'h4FFC);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_rmask_held", {28'b0, dmem_rmask}, 4'b1111);
    do_resp(32'h12345678);
    chk("fl_no_cdb", {31'b0, cdb_valid}, 0);
    chk("fl_idle", {31'b0, in_flight_mem}, 0);
    chk("fl_rmask_drop", {28'b0, dmem_rmask}, 0);
    // misaligned LW 0x4001
    do_issue(1'b0, 3'b010, 32'h4000, 32'h0, 32'h1, 5'd8);
`ifdef MISALIGN_TRAP_EN
    chk("mis_rmask", {28'b0, dmem_rmask}, 0);
    chk("mis_cdb_valid", {31'b0, cdb_valid}, 1);
    chk("mis_exc", {31'b0, cdb_exc}, 1);
    chk("mis_cdb_data", cdb_data, 32'h4001);
    @(negedge clk);
    chk("mis_idle", {31'b0, in_flight_mem}, 0);
`else
    chk("mis_rmask", {28'b0, dmem_rmask}, 4'b1110);
    chk("mis_addr", dmem_addr, 32'h4000);
    do_resp(32'h11223344);
    chk("mis_cdb_data", cdb_data, 32'h00112233);
    chk("mis_exc", {31'b0, cdb_exc}, 0);
    @(negedge clk);
`endif
    // flush during writeback suppresses cdb_valid
    do_issue(1'b0, 3'b001, 32'h6000, 32'h0, 32'h0, 5'd9);
    chk("lhwb_rmask", {28'b0, dmem_rmask}, 4'b0011);
    do_resp(32'h00008001);
    flush = 1'b1;
    #1;
    chk("wbflush_no_cdb", {31'b0, cdb_valid}, 0);
    @(negedge clk);
    // flush together with issue in IDLE drops the issue
    issue_valid = 1'b1; issue_store = 1'b0; issue_funct3 = 3'b010;
    @(negedge clk);
    issue_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_drop", {31'b0, in_flight_mem}, 0);
    // reset in REQ, then a late response
    do_issue(1'b0, 3'b010, 32'h8000, 32'h0, 32'h0, 5'd10);
    rst = 1'b0;
    #1;
    chk("rstreq_rmask", {28'b0, dmem_rmask}, 0);
    chk("rstreq_inflight", {31'b0, in_flight_mem}, 0);
    @(negedge clk); rst = 1'b1;
    do_resp(32'hFFFFFFFF);
    chk("rstreq_late_resp", {31'b0, cdb_valid}, 0);
    chk("rstreq_idle", {31'b0, in_flight_mem}, 0);
    // LHU 0x7002 after reset works normally
    do_issue(1'b0, 3'b101, 32'h7000, 32'h0, 32'h2, 5'd11);
    chk("lhu_rmask", {28'b0, dmem_rmask}, 4'b1100);
    do_resp(32'h87650000);
    chk("lhu_cdb_valid", {31'b0, cdb_valid}, 1);
    chk("lhu_cdb_data", cdb_data, 32'h00008765);
    chk("lhu_cdb_rob", {27'b0, cdb_rob_id}, 11);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
